ff_pulse_sched: RTL

- Round-robin scheduler that shares one timed async-control pulse generator between N requesters.
- Each requester owns a bank of async-clear or async-set flip-flops.
- On grant, drives that bank's clr or set line high for a fixed pulse width, then enforces a recovery gap before the next grant.
- Sits between reset/init logic and the flip-flop banks; all outputs are registered, so there are no combinational glitches on the async pins.

---
 rtl/ff_pulse_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ff_pulse_sched.sv
// Round-robin scheduler that time-shares one async clear/set pulse generator between
// N_REQ flip-flop banks. Every output comes straight from a flop, so the async pins
// never see combinational glitches.
module ff_pulse_sched #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mode,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] clr_out,
    output logic [N_REQ-1:0] set_out,
    output logic [N_REQ-1:0] done,
    output logic             busy
);

    localparam int unsigned      IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPulse,
        StGap
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] clr_q, clr_d;
    logic [N_REQ-1:0] set_q, set_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic             busy_q, busy_d;

    logic             win_found;
    logic [IDX_W-1:0] win_idx;

    // Bank index after i, wrapping at N_REQ (N_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == LAST_IDX) ? '0 : i + IDX_W'(1);
    endfunction

    // Round-robin arbitration: first requesting bank at or after ptr_q.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = ptr_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // Next-state and next-output logic for IDLE -> PULSE -> GAP -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        clr_d   = clr_q;
        set_d   = set_q;
        done_d  = '0;
        busy_d  = busy_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d          = StPulse;
                    cnt_d            = PULSE_LOAD;
                    owner_d          = win_idx;
                    busy_d           = 1'b1;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    // Operation type is fixed here; later mode changes are ignored.
                    clr_d            = '0;
                    set_d            = '0;
                    if (mode[win_idx]) begin
                        set_d[win_idx] = 1'b1;
                    end else begin
                        clr_d[win_idx] = 1'b1;
                    end
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d         = StGap;
                    cnt_d           = GAP_LOAD;
                    clr_d           = '0;
                    set_d           = '0;
                    done_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    ptr_d   = next_idx(owner_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
                clr_d   = '0;
                set_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any pulse without issuing done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            grant_q <= '0;
            clr_q   <= '0;
            set_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            clr_q   <= clr_d;
            set_q   <= set_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign grant   = grant_q;
    assign clr_out = clr_q;
    assign set_out = set_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule
